// File: rtl/pulse_width_meter_pkg.sv
// Shared types and constants for the pulse width meter.
package pulse_width_meter_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } state_e;

    // All-ones value of a w-bit counter (valid for 1 <= w <= 32).
    function automatic logic [31:0] cnt_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous input, followed by a
// one-cycle delay for rise/fall detection. Edges are suppressed until
// both s and its delayed copy hold genuine samples of sig_in, so the
// reset-cleared pipeline never produces a false edge.
module sync_edge_det
    import pulse_width_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES  // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic [SYNC_STAGES:0]   fill_q, fill_d;

    // Next-state of the synchronizer chain, delayed copy and fill tracker.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_d_d  = sync_q[SYNC_STAGES-1];
        fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
    end

    // Synchronizer registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
            fill_q <= fill_d;
        end
    end

    // Synchronized level and qualified edge strobes.
    always_comb begin
        s    = sync_q[SYNC_STAGES-1];
        rise = fill_q[SYNC_STAGES] &  s & ~s_d_q;
        fall = fill_q[SYNC_STAGES] & ~s &  s_d_q;
    end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high time, low time and period (in clk cycles) of an
// asynchronous periodic input, rising edge to rising edge, and presents
// each result over a valid/ready handshake.
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic             sat,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating increment: holds at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic s, rise, fall;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] lc_q, lc_d;
    logic             sat_i_q, sat_i_d;
    logic             publish;

    logic             vld_q, vld_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W:0]   per_q, per_d;
    logic             sat_q, sat_d;
    logic             ovr_q, ovr_d;

    // FSM next-state and counter update; publish strobes on the closing rise.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        lc_d    = lc_q;
        sat_i_d = sat_i_q;
        publish = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hc_d    = '0;
                lc_d    = '0;
                sat_i_d = 1'b0;
                if (en) state_d = ST_ARM;
            end
            ST_ARM: begin
                // Wait for a clean rising edge; whatever came before is partial.
                hc_d    = '0;
                lc_d    = '0;
                sat_i_d = 1'b0;
                if (rise) begin
                    state_d = ST_HIGH;
                    hc_d    = CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_LOW;
                    lc_d    = CNT_ONE;
                end else if (s) begin
                    hc_d = sat_inc(hc_q);
                    if (hc_q == CNT_MAX) sat_i_d = 1'b1;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    // Close this period and start the next one in the same cycle.
                    publish = 1'b1;
                    state_d = ST_HIGH;
                    hc_d    = CNT_ONE;
                    lc_d    = '0;
                    sat_i_d = 1'b0;
                end else if (!s) begin
                    lc_d = sat_inc(lc_q);
                    if (lc_q == CNT_MAX) sat_i_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en) begin
            state_d = ST_IDLE;
            hc_d    = '0;
            lc_d    = '0;
            sat_i_d = 1'b0;
            publish = 1'b0;
        end
    end

    // Result registers, handshake and sticky overrun.
    always_comb begin
        vld_d  = vld_q;
        high_d = high_q;
        low_d  = low_q;
        per_d  = per_q;
        sat_d  = sat_q;
        ovr_d  = ovr_q;
        if (vld_q && meas_ready) vld_d = 1'b0;
        if (publish) begin
            if (!vld_q || meas_ready) begin
                vld_d  = 1'b1;
                high_d = hc_q;
                low_d  = lc_q;
                per_d  = {1'b0, hc_q} + {1'b0, lc_q};
                sat_d  = sat_i_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (!en) ovr_d = 1'b0;
    end

    // State, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hc_q    <= '0;
            lc_q    <= '0;
            sat_i_q <= 1'b0;
            vld_q   <= 1'b0;
            high_q  <= '0;
            low_q   <= '0;
            per_q   <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            lc_q    <= lc_d;
            sat_i_q <= sat_i_d;
            vld_q   <= vld_d;
            high_q  <= high_d;
            low_q   <= low_d;
            per_q   <= per_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    // Output drive.
    always_comb begin
        meas_valid = vld_q;
        high_cnt   = high_q;
        low_cnt    = low_q;
        period_cnt = per_q;
        sat        = sat_q;
        overrun    = ovr_q;
        busy       = (state_q == ST_HIGH) || (state_q == ST_LOW);
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: a 16-bit instance for the main
// scenarios and a 4-bit instance for counter saturation.
module tb_pulse_width_meter;

    localparam int SS = 2;

    typedef struct {
        int h;
        int l;
        int p;
        int s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, sig_in, meas_ready;
    logic        meas_valid, sat, overrun, busy;
    logic [15:0] high_cnt, low_cnt;
    logic [16:0] period_cnt;

    logic        en4, sig4, rdy4;
    logic        vld4, sat4, ovr4, busy4;
    logic [3:0]  high4, low4;
    logic [4:0]  per4;

    exp_t exp_q[$];
    exp_t exp4_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulse_width_meter #(.CNT_W(16), .SYNC_STAGES(SS)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sig_in     (sig_in),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .period_cnt (period_cnt),
        .sat        (sat),
        .overrun    (overrun),
        .busy       (busy)
    );

    pulse_width_meter #(.CNT_W(4), .SYNC_STAGES(SS)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en4),
        .sig_in     (sig4),
        .meas_valid (vld4),
        .meas_ready (rdy4),
        .high_cnt   (high4),
        .low_cnt    (low4),
        .period_cnt (per4),
        .sat        (sat4),
        .overrun    (ovr4),
        .busy       (busy4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        sig_in = v;
        tick(n);
    endtask

    task automatic push(input int h, input int l, input int s);
        exp_t e;
        e.h = h; e.l = l; e.p = h + l; e.s = s;
        exp_q.push_back(e);
    endtask

    task automatic push4(input int h, input int l, input int s);
        exp_t e;
        e.h = h; e.l = l; e.p = h + l; e.s = s;
        exp4_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_meas_valid"}, 32'(meas_valid), 0);
        check({tag, "_high_cnt"},   32'(high_cnt),   0);
        check({tag, "_low_cnt"},    32'(low_cnt),    0);
        check({tag, "_period_cnt"}, 32'(period_cnt), 0);
        check({tag, "_sat"},        32'(sat),        0);
        check({tag, "_overrun"},    32'(overrun),    0);
        check({tag, "_busy"},       32'(busy),       0);
    endtask

    // Monitor for the 16-bit instance: every transfer pops one expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && meas_valid && meas_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got high=%0d low=%0d, expected no result (t=%0t)",
                         high_cnt, low_cnt, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_high_cnt",   32'(high_cnt),   32'(e.h));
                check("res_low_cnt",    32'(low_cnt),    32'(e.l));
                check("res_period_cnt", 32'(period_cnt), 32'(e.p));
                check("res_sat",        32'(sat),        32'(e.s));
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && vld4 && rdy4) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result4: got high=%0d low=%0d, expected no result (t=%0t)",
                         high4, low4, $time);
            end else begin
                exp_t e;
                e = exp4_q.pop_front();
                check("res4_high_cnt",   32'(high4), 32'(e.h));
                check("res4_low_cnt",    32'(low4),  32'(e.l));
                check("res4_period_cnt", 32'(per4),  32'(e.p));
                check("res4_sat",        32'(sat4),  32'(e.s));
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; meas_ready = 1'b1; sig_in = 1'b0;
        en4 = 1'b0; sig4 = 1'b0; rdy4 = 1'b1;
        tick(3);
        check_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // 80/20 waveform; enable while high so the first partial period is discarded.
        sig_in = 1'b1;
        tick(10);
        en = 1'b1;
        tick(10);
        drive(1'b0, 80);
        repeat (3) begin
            push(20, 80, 0);
            drive(1'b1, 20);
            drive(1'b0, 80);
        end

        // Consumer stalls: period 4 held, periods 5 and 6 dropped.
        sig_in = 1'b1;
        tick(8);
        meas_ready = 1'b0;
        check("t1_overrun", 32'(overrun), 0);
        tick(22);
        drive(1'b0, 70);
        drive(1'b1, 25); drive(1'b0, 50);
        drive(1'b1, 25); drive(1'b0, 50);
        sig_in = 1'b1;
        tick(10);
        check("stall_meas_valid", 32'(meas_valid), 1);
        check("stall_high_cnt",   32'(high_cnt),   30);
        check("stall_low_cnt",    32'(low_cnt),    70);
        check("stall_period_cnt", 32'(period_cnt), 100);
        check("stall_overrun",    32'(overrun),    1);
        push(30, 70, 0);
        meas_ready = 1'b1;
        tick(1);
        meas_ready = 1'b0;
        check("accept_meas_valid", 32'(meas_valid), 0);
        tick(9);
        push(20, 80, 0);
        meas_ready = 1'b1;
        drive(1'b0, 80);
        sig_in = 1'b1;
        tick(10);
        check("after_pub_overrun", 32'(overrun), 1);
        tick(10);
        drive(1'b0, 40);
        en = 1'b0;
        tick(2);
        check("en_clr_overrun", 32'(overrun), 0);
        check("en_clr_busy",    32'(busy),    0);

        // Publish lands on the same edge as a transfer of the previous result.
        meas_ready = 1'b0;
        en = 1'b1;
        tick(5);
        drive(1'b1, 15); drive(1'b0, 35);
        drive(1'b1, 12); drive(1'b0, 28);
        sig_in = 1'b1;
        tick(SS);
        push(15, 35, 0);
        meas_ready = 1'b1;
        tick(1);
        meas_ready = 1'b0;
        check("same_cyc_meas_valid", 32'(meas_valid), 1);
        check("same_cyc_high_cnt",   32'(high_cnt),   12);
        check("same_cyc_low_cnt",    32'(low_cnt),    28);
        check("same_cyc_period_cnt", 32'(period_cnt), 40);
        check("same_cyc_overrun",    32'(overrun),    0);

        // en dropped mid-LOW with a pending result.
        tick(20 - SS - 1);
        sig_in = 1'b0;
        tick(10);
        check("midlow_busy", 32'(busy), 1);
        en = 1'b0;
        tick(2);
        check("en_off_busy",       32'(busy),       0);
        check("en_off_meas_valid", 32'(meas_valid), 1);
        check("en_off_high_cnt",   32'(high_cnt),   12);
        push(12, 28, 0);
        meas_ready = 1'b1;
        tick(1);
        check("en_off_accepted", 32'(meas_valid), 0);
        en = 1'b1;
        tick(70);
        push(20, 80, 0);
        drive(1'b1, 20); drive(1'b0, 80);

        // Reset mid-HIGH, then re-arm and discard the partial period.
        sig_in = 1'b1;
        tick(10);
        check("prerst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        tick(3);
        rst_n = 1'b1;
        tick(7);
        drive(1'b0, 80);
        push(20, 80, 0);
        drive(1'b1, 20); drive(1'b0, 80);
        drive(1'b1, 20); drive(1'b0, 10);
        en = 1'b0;

        // 4-bit instance: saturated high time, then an ordinary period.
        en4 = 1'b1;
        tick(3);
        push4(15, 3, 1);
        sig4 = 1'b1; tick(20);
        sig4 = 1'b0; tick(3);
        push4(5, 5, 0);
        sig4 = 1'b1; tick(5);
        sig4 = 1'b0; tick(5);
        sig4 = 1'b1; tick(5);
        sig4 = 1'b0; tick(5);

        tick(5);
        check("pending_expect",  32'(exp_q.size()),  0);
        check("pending_expect4", 32'(exp4_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
